rv32_mc_core: RTL

//  Parametrised multi-cycle RV32I/RV32E core: one instruction at a time, FSM-sequenced, no overlap.

---
 rtl/rv32_mc_core_if.sv | 25 ++
 rtl/rv32_mc_core.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_mc_core_if.sv
// Memory-side bus of rv32_mc_core: separate instruction and data ports.
// master = core side, slave = memory/arbiter side.
interface rv32_mc_core_if;
   logic [31:0] mem_i_addr;
   logic        mem_i_rstrb;
   logic [31:0] mem_i_rdata;
   logic        mem_i_rbusy;
   logic [31:0] mem_d_addr;
   logic [31:0] mem_d_wdata;
   logic [3:0]  mem_d_wmask;
   logic        mem_d_wstrb;
   logic        mem_d_rstrb;
   logic [31:0] mem_d_rdata;
   logic        mem_d_rbusy;
   logic        mem_d_wbusy;

   modport master (
      output mem_i_addr, mem_i_rstrb, mem_d_addr, mem_d_wdata, mem_d_wmask, mem_d_wstrb, mem_d_rstrb,
      input  mem_i_rdata, mem_i_rbusy, mem_d_rdata, mem_d_rbusy, mem_d_wbusy
   );
   modport slave (
      input  mem_i_addr, mem_i_rstrb, mem_d_addr, mem_d_wdata, mem_d_wmask, mem_d_wstrb, mem_d_rstrb,
      output mem_i_rdata, mem_i_rbusy, mem_d_rdata, mem_d_rbusy, mem_d_wbusy
   );
endinterface

// File: rtl/rv32_mc_core.sv
// rv32_mc_core: multi-cycle RV32I/RV32E core, one instruction in flight,
// FETCH/FWAIT/DECODE/EXEC/(MEM/MWAIT)/WB sequencing with a sticky HALT state.
// Optional feature: define RV_ZICNTR_EN to enable cycle/instret counter reads
// via CSRRS rd,csr,x0; otherwise any SYSTEM op except ECALL/EBREAK is illegal.
module rv32_mc_core #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          NREGS    = 32
) (
   input  logic           clk,
   input  logic           rst,
   rv32_mc_core_if.master bus,
   output logic           halted,
   output logic [1:0]     halt_cause
);
   localparam int RW = $clog2(NREGS);
   localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
      OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011, OP_ST = 7'b0100011,
      OP_OPI = 7'b0010011, OP_OP = 7'b0110011, OP_FENCE = 7'b0001111, OP_SYS = 7'b1110011;

   typedef enum logic [2:0] {S_FETCH, S_FWAIT, S_DECODE, S_EXEC, S_MEM, S_MWAIT, S_WB, S_HALT} state_t;
   state_t state, state_n;

   logic [31:0] pc, ir, rs1v, rs2v, res, next_pc, d_addr, d_wdata, ld_word;
   logic [3:0]  wmask;
   logic [31:0] regs [NREGS];
   logic [1:0]  cause_n;

   logic [6:0]  opc, f7;
   logic [2:0]  f3;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   assign opc = ir[6:0];
   assign f3  = ir[14:12];
   assign f7  = ir[31:25];
   assign rd  = ir[11:7];
   assign rs1 = ir[19:15];
   assign rs2 = ir[24:20];
   assign imm_i = {{20{ir[31]}}, ir[31:20]};
   assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
   assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
   assign imm_u = {ir[31:12], 12'd0};
   assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

   logic is_ld, is_st;
   assign is_ld = (opc == OP_LD);
   assign is_st = (opc == OP_ST);

   logic [31:0] csr_val;
`ifdef RV_ZICNTR_EN
   logic [63:0] cyc_cnt, ret_cnt;
   // free-running cycle counter (stops in HALT) and retired-instruction counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc_cnt <= 64'd0;
         ret_cnt <= 64'd0;
      end else begin
         if (state != S_HALT) cyc_cnt <= cyc_cnt + 64'd1;
         if (state == S_WB)   ret_cnt <= ret_cnt + 64'd1;
      end
   end
   // counter CSR read mux
   always_comb begin
      csr_val = 32'd0;
      case (ir[31:20])
         12'hC00: csr_val = cyc_cnt[31:0];
         12'hC80: csr_val = cyc_cnt[63:32];
         12'hC02: csr_val = ret_cnt[31:0];
         12'hC82: csr_val = ret_cnt[63:32];
         default: csr_val = 32'd0;
      endcase
   end
`else
   assign csr_val = 32'd0;
`endif

   // decode: legality, register usage, SYSTEM classification
   logic bad_enc, uses_rd, uses_rs1, uses_rs2, is_ecall, is_ebreak, is_csr, illegal;
   always_comb begin
      bad_enc = 1'b0; uses_rd = 1'b0; uses_rs1 = 1'b0; uses_rs2 = 1'b0;
      is_ecall = 1'b0; is_ebreak = 1'b0; is_csr = 1'b0;
      case (opc)
         OP_LUI, OP_AUIPC, OP_JAL: uses_rd = 1'b1;
         OP_JALR: begin uses_rd = 1'b1; uses_rs1 = 1'b1; bad_enc = (f3 != 3'd0); end
         OP_BR:   begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; bad_enc = (f3[2:1] == 2'b01); end
         OP_LD:   begin uses_rd = 1'b1; uses_rs1 = 1'b1; bad_enc = (f3 == 3'd3) || (f3[2:1] == 2'b11); end
         OP_ST:   begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; bad_enc = f3[2] || (f3 == 3'd3); end
         OP_OPI: begin
            uses_rd = 1'b1; uses_rs1 = 1'b1;
            if (f3 == 3'd1)      bad_enc = (f7 != 7'h00);
            else if (f3 == 3'd5) bad_enc = (f7 != 7'h00) && (f7 != 7'h20);
         end
         OP_OP: begin
            uses_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            bad_enc = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
         end
         OP_FENCE: bad_enc = 1'b0;
         OP_SYS: begin
            if (ir == 32'h0000_0073)      is_ecall  = 1'b1;
            else if (ir == 32'h0010_0073) is_ebreak = 1'b1;
            else begin
`ifdef RV_ZICNTR_EN
               if ((f3 == 3'd2) && (rs1 == 5'd0) && ((ir[31:20] == 12'hC00) || (ir[31:20] == 12'hC80) ||
                   (ir[31:20] == 12'hC02) || (ir[31:20] == 12'hC82))) begin
                  is_csr = 1'b1; uses_rd = 1'b1;
               end else bad_enc = 1'b1;
`else
               bad_enc = 1'b1;
`endif
            end
         end
         default: bad_enc = 1'b1;
      endcase
      illegal = bad_enc || ((NREGS < 32) && ((uses_rd && rd[4]) || (uses_rs1 && rs1[4]) || (uses_rs2 && rs2[4])));
   end

   // execute: ALU, branch compare, next pc, effective address and store lanes
   logic [31:0] op2, alu, next_pc_c, ea, res_c, wdata_c;
   logic [3:0]  mask_c;
   logic        taken, mis_mem, mis;
   always_comb begin
      op2 = (opc == OP_OP) ? rs2v : imm_i;
      case (f3)
         3'd0: alu = ((opc == OP_OP) && f7[5]) ? rs1v - op2 : rs1v + op2;
         3'd1: alu = rs1v << op2[4:0];
         3'd2: alu = ($signed(rs1v) < $signed(op2)) ? 32'd1 : 32'd0;
         3'd3: alu = (rs1v < op2) ? 32'd1 : 32'd0;
         3'd4: alu = rs1v ^ op2;
         3'd5: alu = f7[5] ? $unsigned($signed(rs1v) >>> op2[4:0]) : rs1v >> op2[4:0];
         3'd6: alu = rs1v | op2;
         default: alu = rs1v & op2;
      endcase
      case (f3)
         3'd0: taken = (rs1v == rs2v);
         3'd1: taken = (rs1v != rs2v);
         3'd4: taken = ($signed(rs1v) < $signed(rs2v));
         3'd5: taken = ($signed(rs1v) >= $signed(rs2v));
         3'd6: taken = (rs1v < rs2v);
         3'd7: taken = (rs1v >= rs2v);
         default: taken = 1'b0;
      endcase
      if (opc == OP_JAL)                next_pc_c = pc + imm_j;
      else if (opc == OP_JALR)          next_pc_c = (rs1v + imm_i) & ~32'd1;
      else if ((opc == OP_BR) && taken) next_pc_c = pc + imm_b;
      else                              next_pc_c = pc + 32'd4;
      ea = rs1v + (is_st ? imm_s : imm_i);
      mis_mem = (is_ld || is_st) && (((f3[1:0] == 2'b01) && ea[0]) || ((f3[1:0] == 2'b10) && (ea[1:0] != 2'b00)));
      mis = (next_pc_c[1:0] != 2'b00) || mis_mem;
      case (f3[1:0])
         2'b00:   begin mask_c = 4'b0001 << ea[1:0];       wdata_c = {4{rs2v[7:0]}};  end
         2'b01:   begin mask_c = 4'b0011 << {ea[1], 1'b0}; wdata_c = {2{rs2v[15:0]}}; end
         default: begin mask_c = 4'b1111;                  wdata_c = rs2v;            end
      endcase
      if (opc == OP_LUI)                             res_c = imm_u;
      else if (opc == OP_AUIPC)                      res_c = pc + imm_u;
      else if ((opc == OP_JAL) || (opc == OP_JALR)) res_c = pc + 32'd4;
      else if (is_csr)                               res_c = csr_val;
      else                                           res_c = alu;
   end

   // writeback value: load lane extraction or the EXEC result
   logic [7:0]  lb;
   logic [15:0] lh;
   logic [31:0] wb_val;
   always_comb begin
      case (d_addr[1:0])
         2'd0:    lb = ld_word[7:0];
         2'd1:    lb = ld_word[15:8];
         2'd2:    lb = ld_word[23:16];
         default: lb = ld_word[31:24];
      endcase
      lh = d_addr[1] ? ld_word[31:16] : ld_word[15:0];
      wb_val = res;
      if (is_ld) begin
         case (f3)
            3'd0:    wb_val = {{24{lb[7]}}, lb};
            3'd1:    wb_val = {{16{lh[15]}}, lh};
            3'd4:    wb_val = {24'd0, lb};
            3'd5:    wb_val = {16'd0, lh};
            default: wb_val = ld_word;
         endcase
      end
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_FETCH;
      else     state <= state_n;
   end

   // next-state and halt cause selection
   always_comb begin
      state_n = state;
      cause_n = 2'd0;
      case (state)
         S_FETCH:  state_n = S_FWAIT;
         S_FWAIT:  if (!bus.mem_i_rbusy) state_n = S_DECODE;
         S_DECODE: begin
            if (illegal)        begin state_n = S_HALT; cause_n = 2'd2; end
            else if (is_ecall)  begin state_n = S_HALT; cause_n = 2'd1; end
            else if (is_ebreak) begin state_n = S_HALT; cause_n = 2'd0; end
            else                state_n = S_EXEC;
         end
         S_EXEC: begin
            if (mis)                 begin state_n = S_HALT; cause_n = 2'd3; end
            else if (is_ld || is_st) state_n = S_MEM;
            else                     state_n = S_WB;
         end
         S_MEM:   state_n = S_MWAIT;
         S_MWAIT: if (!(is_ld ? bus.mem_d_rbusy : bus.mem_d_wbusy)) state_n = S_WB;
         S_WB:    state_n = S_FETCH;
         S_HALT:  state_n = S_HALT;
         default: state_n = S_FETCH;
      endcase
   end

   // datapath registers and register file
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC; ir <= 32'd0; rs1v <= 32'd0; rs2v <= 32'd0; res <= 32'd0;
         next_pc <= RESET_PC; d_addr <= 32'd0; d_wdata <= 32'd0; ld_word <= 32'd0;
         wmask <= 4'd0; halt_cause <= 2'd0;
         for (int i = 0; i < NREGS; i++) regs[i] <= 32'd0;
      end else begin
         case (state)
            S_FWAIT:  if (!bus.mem_i_rbusy) ir <= bus.mem_i_rdata;
            S_DECODE: begin
               rs1v <= (rs1 == 5'd0) ? 32'd0 : regs[rs1[RW-1:0]];
               rs2v <= (rs2 == 5'd0) ? 32'd0 : regs[rs2[RW-1:0]];
            end
            S_EXEC: begin
               res     <= res_c;
               next_pc <= next_pc_c;
               if ((is_ld || is_st) && !mis_mem) begin
                  d_addr  <= ea;
                  d_wdata <= wdata_c;
                  wmask   <= is_st ? mask_c : 4'd0;
               end
            end
            S_MWAIT:  if (is_ld && !bus.mem_d_rbusy) ld_word <= bus.mem_d_rdata;
            S_WB: begin
               if (uses_rd && (rd != 5'd0)) regs[rd[RW-1:0]] <= wb_val;
               pc    <= next_pc;
               wmask <= 4'd0;
            end
            default: ;
         endcase
         if ((state != S_HALT) && (state_n == S_HALT)) halt_cause <= cause_n;
      end
   end

   // strobes are gated by rst so an in-flight access is dropped the moment reset asserts
   assign bus.mem_i_addr  = pc;
   assign bus.mem_i_rstrb = (state == S_FETCH) && !rst;
   assign bus.mem_d_rstrb = (state == S_MEM) && is_ld && !rst;
   assign bus.mem_d_wstrb = (state == S_MEM) && is_st && !rst;
   assign bus.mem_d_addr  = d_addr;
   assign bus.mem_d_wdata = d_wdata;
   assign bus.mem_d_wmask = wmask;
   assign halted          = (state == S_HALT);
endmodule
